// File: rtl/des3_iter_core.sv
// rtl/des3_iter_core.sv - iterative valid/ready Triple-DES (EDE) engine, ROUNDS_PER_CYCLE rounds per clock
// Optional DES3_KEY3_EN adds the K3 port (3-key EDE); otherwise the third pass reuses K1.
module des3_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_W            = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [63:0] K1,
  input  logic [63:0] K2,
`ifdef DES3_KEY3_EN
  input  logic [63:0] K3,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(48 / ROUNDS_PER_CYCLE - 1);

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int S_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Tables use FIPS numbering: entry n selects input bit n counted from the MSB (bit 1).
  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63-i)] = x[6'(64-IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63-i)] = x[6'(64-FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55-i)] = x[6'(64-PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47-i)] = x[6'(56-PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  s;
    logic [31:0] y;
    logic [31:0] z;
    for (int i = 0; i < 48; i++) x[6'(47-i)] = r[5'(32-E_T[6'(i)])];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      s = x[6'(47-6*b) -: 6];
      y[5'(31-4*b) -: 4] = 4'(S_T[3'(b)][{s[5], s[0], s[4:1]}]);
    end
    for (int i = 0; i < 32; i++) z[5'(31-i)] = y[5'(32-P_T[5'(i)])];
    return z;
  endfunction

  function automatic logic [55:0] rot_l(input logic [55:0] c, input int n);
    if (n == 1) return {c[54:28], c[55], c[26:0], c[27]};
    return {c[53:28], c[55:54], c[25:0], c[27:26]};
  endfunction

  function automatic logic [55:0] rot_r(input logic [55:0] c, input int n);
    if (n == 1) return {c[28], c[55:29], c[0], c[27:1]};
    return {c[29:28], c[55:30], c[1:0], c[27:2]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      lr_q, lr_nx;
  logic [55:0]      cd_q, cd_nx;
  logic [63:0]      k1_q, k2_q, k3_q;
  logic             dec_q;

  int          base, rnd;
  logic        pass_dec;
  logic [63:0] pk;
  logic [55:0] c;
  logic [47:0] sk;
  logic [31:0] l, r, t;

  // Passes never straddle a clock since ROUNDS_PER_CYCLE divides 16; the key schedule reloads at round 0.
  always_comb begin
    base     = int'(cnt_q) * ROUNDS_PER_CYCLE;
    rnd      = 0;
    sk       = '0;
    t        = '0;
    pass_dec = dec_q ^ (base / 16 == 1);
    if (base / 16 == 1)                pk = k2_q;
    else if ((base / 16 == 0) ^ dec_q) pk = k1_q;
    else                               pk = k3_q;
    c      = (base % 16 == 0) ? f_pc1(pk) : cd_q;
    {l, r} = lr_q;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd = base % 16 + j;
      if (!pass_dec) c = rot_l(c, SHIFT_T[4'(rnd)]);
      sk = f_pc2(c);
      if (pass_dec) c = rot_r(c, SHIFT_T[4'(15 - rnd)]);
      t = l ^ f_feistel(r, sk);
      // Round 16 skips the swap, which also yields the R16/L16 pre-output that feeds the next pass.
      if (rnd == 15) l = t;
      else begin
        l = r;
        r = t;
      end
    end
    lr_nx = {l, r};
    cd_nx = c;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_nx = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifndef DES3_KEY3_EN
  assign k3_q = k1_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lr_q     <= '0;
      cd_q     <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
`ifdef DES3_KEY3_EN
      k3_q     <= '0;
`endif
      dec_q    <= 1'b0;
      data_out <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == S_IDLE && in_valid) begin
        lr_q  <= f_ip(data_in);
        k1_q  <= K1;
        k2_q  <= K2;
`ifdef DES3_KEY3_EN
        k3_q  <= K3;
`endif
        dec_q <= decrypt;
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        lr_q  <= lr_nx;
        cd_q  <= cd_nx;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) data_out <= f_fp(lr_nx);
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_des3_iter_core.sv
// tb/tb_des3_iter_core.sv - scoreboard bench for des3_iter_core at 1, 4 and 16 rounds per cycle
// Build with or without DES3_KEY3_EN; the K3 ports and 3-key scenario follow the macro.
module tb_des3_iter_core;

  typedef struct {
    logic        chk;
    logic [63:0] data;
    int          lat;
  } exp_t;

  localparam int LAT [3] = '{48, 12, 3};
  localparam logic [63:0] KA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB = 64'hECCBA8866443200E;
  localparam logic [63:0] PA = 64'h0123456789ABCDEF;
  localparam logic [63:0] CA = 64'h85E813540F0AB405;
  localparam logic [63:0] KZ = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PZ = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv [3], dec [3], ordy [3], ir [3], ov [3], bsy [3];
  logic [63:0] din [3], k1 [3], k2 [3], k3 [3], dout [3];

  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  des3_iter_core #(.ROUNDS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .decrypt(dec[0]), .data_in(din[0]),
    .K1(k1[0]), .K2(k2[0]),
`ifdef DES3_KEY3_EN
    .K3(k3[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]), .busy(bsy[0]));

  des3_iter_core #(.ROUNDS_PER_CYCLE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .decrypt(dec[1]), .data_in(din[1]),
    .K1(k1[1]), .K2(k2[1]),
`ifdef DES3_KEY3_EN
    .K3(k3[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]), .busy(bsy[1]));

  des3_iter_core #(.ROUNDS_PER_CYCLE(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .decrypt(dec[2]), .data_in(din[2]),
    .K1(k1[2]), .K2(k2[2]),
`ifdef DES3_KEY3_EN
    .K3(k3[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]), .busy(bsy[2]));

  // Runs one block on instance idx; with hold>0 the sink stalls in DONE while a new request is offered.
  task automatic do_block(input int idx, input logic d, input logic [63:0] data, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c, input logic chk,
                          input logic [63:0] exp, input int hold, output logic [63:0] res);
    exp_t e;
    int   cyc;
    logic seen;
    logic [63:0] held;
    e.chk = chk; e.data = exp; e.lat = LAT[idx];
    sb.push_back(e);
    @(negedge clk);
    iv[idx] = 1'b1; dec[idx] = d; din[idx] = data; k1[idx] = a; k2[idx] = b; k3[idx] = c;
    ordy[idx] = (hold == 0);
    @(posedge clk); #1;
    n_chk++;
    if (ir[idx] !== 1'b0 || bsy[idx] !== 1'b1 || ov[idx] !== 1'b0)
      begin n_fail++; $display("FAIL accept[%0d]: in_ready=%b busy=%b out_valid=%b, want 0 1 0", idx, ir[idx], bsy[idx], ov[idx]); end
    iv[idx] = 1'b0; dec[idx] = ~d; din[idx] = ~data; k1[idx] = ~a; k2[idx] = ~b; k3[idx] = ~c;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      seen = ov[idx];
    end
    e = sb.pop_front();
    res = dout[idx];
    n_chk++;
    if (!seen || cyc != e.lat)
      begin n_fail++; $display("FAIL latency[%0d]: got %0d cycles (seen=%b), want %0d", idx, cyc, seen, e.lat); end
    if (e.chk) begin
      n_chk++;
      if (dout[idx] !== e.data)
        begin n_fail++; $display("FAIL data_out[%0d]: got %h, want %h", idx, dout[idx], e.data); end
    end
    if (hold > 0) begin
      held = dout[idx];
      iv[idx] = 1'b1; din[idx] = data ^ 64'h1; dec[idx] = ~d;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        n_chk++;
        if (ov[idx] !== 1'b1 || ir[idx] !== 1'b0 || dout[idx] !== held)
          begin n_fail++; $display("FAIL hold[%0d] cycle %0d: out_valid=%b in_ready=%b data_out=%h, want 1 0 %h", idx, i, ov[idx], ir[idx], dout[idx], held); end
      end
      iv[idx] = 1'b0;
      ordy[idx] = 1'b1;
    end
    @(posedge clk); #1;
    n_chk++;
    if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1 || bsy[idx] !== 1'b0 || dout[idx] !== res)
      begin n_fail++; $display("FAIL release[%0d]: out_valid=%b in_ready=%b busy=%b data_out=%h, want 0 1 0 %h", idx, ov[idx], ir[idx], bsy[idx], dout[idx], res); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; dec[i] = 1'b0; ordy[i] = 1'b0;
      din[i] = '0; k1[i] = '0; k2[i] = '0; k3[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || bsy[i] !== 1'b0 || dout[i] !== 64'h0)
        begin n_fail++; $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 0", i, ir[i], ov[i], bsy[i], dout[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known_vectors();
    logic [63:0] res;
    do_block(0, 1'b0, PA, KA, KA, KA, 1'b1, CA, 0, res);
    do_block(0, 1'b1, CA, KA, KA, KA, 1'b1, PA, 0, res);
    for (int i = 1; i < 3; i++) begin
      do_block(i, 1'b0, PA, KA, KA, KA, 1'b1, CA, 0, res);
      do_block(i, 1'b0, PZ, KZ, KZ, KZ, 1'b1, 64'h0, 0, res);
      do_block(i, 1'b1, 64'h0, KZ, KZ, KZ, 1'b1, PZ, 0, res);
    end
  endtask

  task automatic test_round_trip();
    logic [63:0] p, c0, res;
    for (int n = 0; n < 2; n++) begin
      p = {$urandom, $urandom};
      do_block(0, 1'b0, p, KA, KB, KA, 1'b0, 64'h0, 0, c0);
      n_chk++;
      if (c0 === p) begin n_fail++; $display("FAIL enc_changes: got %h, want != %h", c0, p); end
      do_block(1, 1'b0, p, KA, KB, KA, 1'b1, c0, 0, res);
      do_block(2, 1'b0, p, KA, KB, KA, 1'b1, c0, 0, res);
      for (int i = 0; i < 3; i++) do_block(i, 1'b1, c0, KA, KB, KA, 1'b1, p, 0, res);
    end
  endtask

`ifdef DES3_KEY3_EN
  task automatic test_key3();
    logic [63:0] p, c2, c3, res;
    p = {$urandom, $urandom};
    do_block(0, 1'b0, p, KA, KB, KA, 1'b0, 64'h0, 0, c2);
    do_block(0, 1'b0, p, KA, KB, KZ, 1'b0, 64'h0, 0, c3);
    n_chk++;
    if (c3 === c2) begin n_fail++; $display("FAIL key3_differs: got %h, want != %h", c3, c2); end
    do_block(1, 1'b0, p, KA, KB, KZ, 1'b1, c3, 0, res);
    for (int i = 0; i < 3; i++) do_block(i, 1'b1, c3, KA, KB, KZ, 1'b1, p, 0, res);
  endtask
`endif

  task automatic test_hold_done();
    logic [63:0] res;
    do_block(0, 1'b0, PA, KA, KA, KA, 1'b1, CA, 20, res);
    do_block(0, 1'b1, CA, KA, KA, KA, 1'b1, PA, 0, res);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] res;
    @(negedge clk);
    iv[0] = 1'b1; dec[0] = 1'b0; din[0] = PZ; k1[0] = KZ; k2[0] = KZ; k3[0] = KZ; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || dout[0] !== 64'h0)
      begin n_fail++; $display("FAIL reset_mid_run: in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 0", ir[0], ov[0], bsy[0], dout[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    do_block(0, 1'b0, PA, KA, KA, KA, 1'b1, CA, 0, res);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.chk = 1'b1; e.data = CA; e.lat = 3 + 5 * k;
      sb.push_back(e);
    end
    @(negedge clk);
    iv[2] = 1'b1; dec[2] = 1'b0; din[2] = PA; k1[2] = KA; k2[2] = KA; k3[2] = KA; ordy[2] = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (ov[2] === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: out_valid at cycle %0d, want none", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.lat || dout[2] !== CA)
            begin n_fail++; $display("FAIL b2b: got cycle %0d data %h, want cycle %0d data %h", cyc, dout[2], e.lat, CA); end
        end
      end
    end
    iv[2] = 1'b0;
    n_chk++;
    if (sb.size() != 0)
      begin n_fail++; $display("FAIL b2b_count: got %0d outstanding, want 0", sb.size()); sb.delete(); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_round_trip();
`ifdef DES3_KEY3_EN
    test_key3();
`endif
    test_hold_done();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
